// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types: FSM states, length codes, IO region default.
// Imported by mem_arbiter and mem_arbiter_icache_store.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    FILL = 2'd3
  } state_t;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_B:   n = 3'd1;
      LEN_H:   n = 3'd2;
      LEN_W:   n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter_icache_store.sv
// Direct-mapped icache arrays: valid/tag/data with lookup, line write, invalidate.
// Ports: lk_* combinational lookup, wr_* full-line fill, inv_* tag-checked invalidate.
module mem_arbiter_icache_store
  import mem_arbiter_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [31:0]             lk_addr,
  output logic                    lk_hit,
  output logic [32*LINE_WORDS-1:0] lk_line,
  input  logic                    wr_en,
  input  logic [31:0]             wr_addr,
  input  logic [32*LINE_WORDS-1:0] wr_line,
  input  logic                    inv_en,
  input  logic [31:0]             inv_addr
);

  localparam int OFF_W = $clog2(4 * LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  logic [LINES-1:0]          valid;
  logic [TAG_W-1:0]          tags [LINES];
  logic [32*LINE_WORDS-1:0]  data [LINES];

  logic [IDX_W-1:0] lk_idx, wr_idx, inv_idx;
  logic [TAG_W-1:0] lk_tag, wr_tag, inv_tag;
  logic             unused_low;

  assign lk_idx  = lk_addr[OFF_W +: IDX_W];
  assign wr_idx  = wr_addr[OFF_W +: IDX_W];
  assign inv_idx = inv_addr[OFF_W +: IDX_W];
  assign lk_tag  = lk_addr[31 -: TAG_W];
  assign wr_tag  = wr_addr[31 -: TAG_W];
  assign inv_tag = inv_addr[31 -: TAG_W];

  assign unused_low = ^{lk_addr[OFF_W-1:0],
                        wr_addr[OFF_W-1:0],
                        inv_addr[OFF_W-1:0]};

  assign lk_hit  = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign lk_line = data[lk_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (rdy) begin
      if (wr_en)
        valid[wr_idx] <= 1'b1;
      if (inv_en && valid[inv_idx] &&
          tags[inv_idx] == inv_tag)
        valid[inv_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter: store > load > fetch onto mem_a/mem_dout/mem_wr/mem_din.
// Optional icache with burst line fill and store coherence: MEMCTL_ICACHE_EN.
// Ports: clk/rst/rdy, io_buffer_full, flush, st_*/ld_*/if_* request ports
// with *_done pulses, mem_* RAM/IO bus.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ICACHE_LINES = 16,
  parameter int         LINE_WORDS   = 4,
  parameter logic [1:0] IO_SEL       = IO_SEL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        io_buffer_full,
  input  logic        flush,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_len,
  input  logic [31:0] st_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_len,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic        st_done,
  output logic        ld_done,
  output logic [31:0] ld_data,
  output logic        if_done,
  output logic [31:0] if_inst
);

  localparam int LB = 4 * LINE_WORDS;
  localparam int CW = $clog2(LB) + 1;
`ifdef MEMCTL_ICACHE_EN
  localparam int FN = LB;
`else
  localparam int FN = 4;
  localparam int unused_lines = ICACHE_LINES;
`endif
  localparam int FW = 8 * FN;
  localparam logic [CW-1:0] FN_C = CW'(FN);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt, idx, st_n, ld_n;
  logic [31:0]   rbuf, rbuf_nx, fill_base, fill_word;
  logic [FW-1:0] lbuf, lbuf_nx;
  logic          io_stall, acc_st, acc_ld, acc_if;
  logic          wr_go, rd_go, fl_go, hit;
  logic [31:0]   hit_word;

  assign st_n = CW'(len_bytes(st_len));
  assign ld_n = CW'(len_bytes(ld_len));

  // In IDLE the accepted request drives byte 0 in the same cycle.
  assign idx = (state == IDLE) ? '0 : cnt;

  assign io_stall = (st_addr[17:16] == IO_SEL) && io_buffer_full;

  assign acc_st = (state == IDLE) && st_req;
  assign acc_ld = (state == IDLE) && !st_req && ld_req && !flush;
  assign acc_if = (state == IDLE) && !st_req && !ld_req &&
                  if_req && !flush;

  assign wr_go = acc_st || (state == WR && cnt < st_n);
  assign rd_go = acc_ld || (state == RD && cnt < ld_n);
  assign fl_go = (acc_if && !hit) ||
                 (state == FILL && cnt < FN_C);

  // mem_din in cycle A+cnt carries byte cnt-1.
  assign rbuf_nx = rbuf |
    (32'(mem_din) << {cnt - ONE, 3'b000});
  assign lbuf_nx = lbuf |
    (FW'(mem_din) << {cnt - ONE, 3'b000});

`ifdef MEMCTL_ICACHE_EN
  logic [31:0]   widx;
  logic [FW-1:0] hit_line;
  logic          fill_wr, inv_en;

  assign widx      = (if_addr >> 2) & 32'(LINE_WORDS - 1);
  assign fill_base = if_addr & ~32'(LB - 1);
  assign fill_word = 32'(lbuf_nx >> {widx, 5'b00000});
  assign hit_word  = 32'(hit_line >> {widx, 5'b00000});
  assign fill_wr   = (state == FILL) && (cnt == FN_C) && !flush;
  // Drop any cached copy of the stored line in the st_done cycle.
  assign inv_en    = (state == WR) && (cnt >= st_n);

  mem_arbiter_icache_store #(
    .LINES      (ICACHE_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_icache (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .lk_addr  (if_addr),
    .lk_hit   (hit),
    .lk_line  (hit_line),
    .wr_en    (fill_wr),
    .wr_addr  (fill_base),
    .wr_line  (lbuf_nx),
    .inv_en   (inv_en),
    .inv_addr (st_addr)
  );
`else
  assign fill_base = if_addr;
  assign fill_word = lbuf_nx;
  assign hit       = 1'b0;
  assign hit_word  = '0;
`endif

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    unique case (1'b1)
      wr_go: begin
        if (!io_stall) begin
          mem_a    = st_addr + 32'(idx);
          mem_dout = 8'(st_data >> {idx, 3'b000});
          mem_wr   = rdy;
        end
      end
      rd_go: mem_a = ld_addr + 32'(idx);
      fl_go: mem_a = fill_base + 32'(idx);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rbuf    <= '0;
      lbuf    <= '0;
      st_done <= 1'b0;
      ld_done <= 1'b0;
      if_done <= 1'b0;
      ld_data <= '0;
      if_inst <= '0;
    end else if (rdy) begin
      st_done <= 1'b0;
      ld_done <= 1'b0;
      if_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc_st) begin
            if (!io_stall) begin
              state   <= WR;
              cnt     <= ONE;
              st_done <= (st_n == ONE);
            end
          end else if (acc_ld) begin
            state <= RD;
            cnt   <= ONE;
            rbuf  <= '0;
          end else if (acc_if) begin
            state <= FILL;
            if (hit) begin
              // Park past the fill end so FILL just returns to IDLE.
              cnt     <= FN_C + ONE;
              if_done <= 1'b1;
              if_inst <= hit_word;
            end else begin
              cnt  <= ONE;
              lbuf <= '0;
            end
          end
        end
        WR: begin
          if (cnt >= st_n) begin
            state <= IDLE;
          end else if (!io_stall) begin
            cnt     <= cnt + ONE;
            st_done <= ((cnt + ONE) == st_n);
          end
        end
        RD: begin
          if (flush || cnt > ld_n) begin
            state <= IDLE;
          end else begin
            rbuf <= rbuf_nx;
            cnt  <= cnt + ONE;
            if (cnt == ld_n) begin
              ld_done <= 1'b1;
              ld_data <= rbuf_nx;
            end
          end
        end
        FILL: begin
          if (flush || cnt > FN_C) begin
            state <= IDLE;
          end else begin
            lbuf <= lbuf_nx;
            cnt  <= cnt + ONE;
            if (cnt == FN_C) begin
              if_done <= 1'b1;
              if_inst <= fill_word;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte RAM model.
// RAM byte at address a is initialised to a[7:0].
module tb_mem_arbiter;

`ifdef MEMCTL_ICACHE_EN
  localparam int FILL_LAT = 17;
  localparam int HIT_LAT  = 1;
  localparam int FLUSH_AT = 6;
`else
  localparam int FILL_LAT = 5;
  localparam int HIT_LAT  = 5;
  localparam int FLUSH_AT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full, flush;
  logic        st_req, ld_req, if_req;
  logic [31:0] st_addr, st_data, ld_addr, if_addr;
  logic [1:0]  st_len, ld_len;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a, ld_data, if_inst;
  logic        mem_wr, st_done, ld_done, if_done;

  logic [7:0] ram [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr && mem_a[17:16] != 2'b11)
      ram[mem_a[15:0]] <= mem_dout;
  end

  mem_arbiter #(
    .ICACHE_LINES (16),
    .LINE_WORDS   (4),
    .IO_SEL       (2'b11)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .io_buffer_full (io_buffer_full),
    .flush          (flush),
    .st_req         (st_req),
    .st_addr        (st_addr),
    .st_len         (st_len),
    .st_data        (st_data),
    .ld_req         (ld_req),
    .ld_addr        (ld_addr),
    .ld_len         (ld_len),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .st_done        (st_done),
    .ld_done        (ld_done),
    .ld_data        (ld_data),
    .if_done        (if_done),
    .if_inst        (if_inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    case (w)
      0:       return st_done;
      1:       return ld_done;
      default: return if_done;
    endcase
  endfunction

  // Starts at the sampling point of the accept cycle; returns cycles to done.
  task automatic wait_done(input int w, output int lat);
    lat = 0;
    while (!done_of(w) && lat < 40) begin
      @(posedge clk); #1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] len,
                          input int n, input logic [31:0] d,
                          input string tag);
    st_addr = a; st_len = len; st_data = d; st_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({tag, " wr"}, 32'(mem_wr), 32'd1);
      chk({tag, " a"}, mem_a, a + k);
      chk({tag, " dout"}, 32'(mem_dout), (d >> (8 * k)) & 32'hFF);
      step();
    end
    @(negedge clk);
    chk({tag, " done"}, 32'(st_done), 32'd1);
    chk({tag, " wr_end"}, 32'(mem_wr), 32'd0);
    step();
    st_req = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] len,
                         input int lat_exp, input logic [31:0] exp,
                         input string tag);
    int lat;
    ld_addr = a; ld_len = len; ld_req = 1'b1;
    @(negedge clk);
    chk({tag, " a0"}, mem_a, a);
    wait_done(1, lat);
    chk({tag, " lat"}, 32'(lat), 32'(lat_exp));
    chk({tag, " data"}, ld_data, exp);
    step();
    ld_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, input int lat_exp,
                          input logic [31:0] exp, input string tag);
    int lat;
    if_addr = a; if_req = 1'b1;
    @(negedge clk);
    wait_done(2, lat);
    chk({tag, " lat"}, 32'(lat), 32'(lat_exp));
    chk({tag, " inst"}, if_inst, exp);
    step();
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nd;
    for (int i = 0; i < 65536; i++) ram[i] = i[7:0];
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    st_req = 1'b0; ld_req = 1'b0; if_req = 1'b0;
    st_addr = '0; st_data = '0; st_len = '0;
    ld_addr = '0; ld_len = '0; if_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst st_done", 32'(st_done), 0);
    chk("rst ld_done", 32'(ld_done), 0);
    chk("rst if_done", 32'(if_done), 0);
    chk("rst ld_data", ld_data, 0);
    chk("rst if_inst", if_inst, 0);
    chk("rst mem_wr", 32'(mem_wr), 0);
    chk("rst mem_a", mem_a, 0);
    chk("rst mem_dout", 32'(mem_dout), 0);
    step();

    do_store(32'h100, 2'd2, 4, 32'hDEADBEEF, "st_w");
    do_load(32'h100, 2'd2, 5, 32'hDEADBEEF, "ld_w");
    do_load(32'h101, 2'd1, 3, 32'h0000ADBE, "ld_h");
    do_load(32'h103, 2'd0, 2, 32'h000000DE, "ld_b");

    do_fetch(32'h40, FILL_LAT, 32'h43424140, "if_cold");
    do_fetch(32'h44, HIT_LAT, 32'h47464544, "if_hit");
    do_fetch(32'h4C, HIT_LAT, 32'h4F4E4D4C, "if_hit_last");

    ld_addr = 32'h104; ld_len = 2'd2; ld_req = 1'b1;
    if_addr = 32'h80; if_req = 1'b1;
    do_store(32'h200, 2'd0, 1, 32'h77, "pri_st");
    @(negedge clk);
    chk("pri ld_a", mem_a, 32'h104);
    chk("pri ld_wr", 32'(mem_wr), 0);
    wait_done(1, lat);
    chk("pri ld lat", 32'(lat), 5);
    chk("pri ld data", ld_data, 32'h07060504);
    step();
    ld_req = 1'b0;
    @(negedge clk);
    chk("pri if_a", mem_a, 32'h80);
    wait_done(2, lat);
    chk("pri if lat", 32'(lat), 32'(FILL_LAT));
    chk("pri if inst", if_inst, 32'h83828180);
    step();
    if_req = 1'b0;

    st_addr = 32'h30000; st_len = 2'd0; st_data = 32'h41;
    io_buffer_full = 1'b1; st_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("io stall wr", 32'(mem_wr), 0);
      chk("io stall done", 32'(st_done), 0);
      step();
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    chk("io wr", 32'(mem_wr), 1);
    chk("io a", mem_a, 32'h30000);
    chk("io dout", 32'(mem_dout), 32'h41);
    step();
    @(negedge clk);
    chk("io done", 32'(st_done), 1);
    chk("io wr_end", 32'(mem_wr), 0);
    step();
    st_req = 1'b0;
    @(negedge clk);
    chk("io done once", 32'(st_done), 0);
    step();

    rdy = 1'b0;
    st_addr = 32'h300; st_len = 2'd0; st_data = 32'h99; st_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rdy0 wr", 32'(mem_wr), 0);
      step();
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("rdy1 wr", 32'(mem_wr), 1);
    chk("rdy1 a", mem_a, 32'h300);
    step();
    @(negedge clk);
    chk("rdy1 done", 32'(st_done), 1);
    step();
    st_req = 1'b0;

    ld_addr = 32'h108; ld_len = 2'd2; ld_req = 1'b1;
    nd = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 2) begin flush = 1'b1; ld_req = 1'b0; end
      if (k == 3) flush = 1'b0;
      @(negedge clk);
      if (ld_done) nd++;
      if (k == 3) chk("ldflush idle", mem_a, 0);
      step();
    end
    chk("ldflush no done", 32'(nd), 0);

    if_addr = 32'hC0; if_req = 1'b1;
    nd = 0;
    for (int k = 0; k < FLUSH_AT + 20; k++) begin
      if (k == FLUSH_AT) begin flush = 1'b1; if_req = 1'b0; end
      if (k == FLUSH_AT + 1) flush = 1'b0;
      @(negedge clk);
      if (if_done) nd++;
      if (k == FLUSH_AT + 1) chk("ifflush idle", mem_a, 0);
      step();
    end
    chk("ifflush no done", 32'(nd), 0);
    do_fetch(32'hC0, FILL_LAT, 32'hC3C2C1C0, "if_refill");

    if_addr = 32'h44; if_req = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flushhit a", mem_a, 0);
    step();
    flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("flushhit no done", 32'(if_done), 0);
    step();

    do_fetch(32'h40, HIT_LAT, 32'h43424140, "coh pre");
    do_store(32'h44, 2'd2, 4, 32'h12345678, "coh_st");
    do_fetch(32'h44, FILL_LAT, 32'h12345678, "coh post");

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    do_fetch(32'h40, FILL_LAT, 32'h43424140, "rst inval");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
